fifo_sr_fwft: RTL and testbench

- Synchronous first-word-fall-through FIFO controller that owns one instance of the team's two-port RAM (mem2p_sw_sr).
- That RAM has one write port and a synchronous-read port with registered address, so read data appears one cycle after the address.
- This block drives the RAM write port and read address, and absorbs the one-cycle read latency with a prefetch and a 2-entry output stage.
- It presents a valid/ready head-of-queue to downstream QuickQ logic at full throughput: one push and one pop per cycle.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/mem2p_sw_sr.sv | 27 ++
 rtl/fifo_sr_fwft.sv | 114 +++++++++++
 tb/tb_fifo_sr_fwft.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO slice: count-width sizing and depth legality.
package fifo_pkg;

  // Bits needed to hold a count of 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/mem2p_sw_sr.sv
// Two-port RAM: one write port, one synchronous-read port with registered
// address, so dout2 reflects the address presented on the previous edge.
module mem2p_sw_sr #(
  parameter  int W  = 8,
  parameter  int D  = 128,
  localparam int DW = $clog2(D)
) (
  input  logic          clk,
  input  logic          we1,
  input  logic [DW-1:0] addr1,
  input  logic [W-1:0]  din1,
  input  logic [DW-1:0] addr2,
  output logic [W-1:0]  dout2
);

  logic [W-1:0]  r_mem [D];
  logic [DW-1:0] r_addr2;

  // Write port and read-address register.
  always_ff @(posedge clk) begin
    if (we1) r_mem[addr1] <= din1;
    r_addr2 <= addr2;
  end

  assign dout2 = r_mem[r_addr2];

endmodule

// File: rtl/fifo_sr_fwft.sv
// First-word-fall-through FIFO over a synchronous-read RAM. A prefetch and a
// two-entry output stage hide the RAM read latency so one push and one pop
// can be accepted every cycle.
module fifo_sr_fwft
  import fifo_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int D  = 128,
  localparam int DW = $clog2(D),
  localparam int CW = cnt_width(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  output logic          full,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic [CW-1:0] count
);

  if (!is_pow2(D)) begin : g_depth_check
    $error("fifo_sr_fwft: D must be a power of two");
  end

  logic [DW-1:0] r_wr_ptr;
  logic [DW-1:0] r_rd_ptr;
  logic [CW-1:0] r_ram_cnt;
  logic [CW-1:0] r_count;
  logic          r_pend;
  logic [1:0]    r_occ;
  logic [W-1:0]  r_slot0;
  logic [W-1:0]  r_slot1;

  logic          w_push;
  logic          w_pop;
  logic          w_fetch;
  logic [1:0]    w_occ_mid;
  logic [1:0]    w_load;
  logic [W-1:0]  w_dout2;

  assign full     = (r_count == CW'(D));
  assign count    = r_count;
  assign rd_valid = (r_occ != 2'd0);
  assign rd_data  = r_slot0;

  // Accept conditions and prefetch decision. The stage may hold at most two
  // entries once the in-flight fetch lands, counted after this cycle's pop.
  always_comb begin
    w_push    = wr_en && !full;
    w_pop     = rd_en && (r_occ != 2'd0);
    w_occ_mid = r_occ - {1'b0, w_pop};
    w_load    = w_occ_mid + {1'b0, r_pend};
    w_fetch   = (r_ram_cnt != '0) && (w_load < 2'd2);
  end

  mem2p_sw_sr #(
    .W (W),
    .D (D)
  ) u_mem (
    .clk   (clk),
    .we1   (w_push),
    .addr1 (r_wr_ptr),
    .din1  (wr_data),
    .addr2 (r_rd_ptr),
    .dout2 (w_dout2)
  );

  // Pointers, RAM-resident count, fetch-pending flag and total count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_pend    <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + DW'(1);
      if (w_fetch) r_rd_ptr <= r_rd_ptr + DW'(1);
      r_ram_cnt <= r_ram_cnt + CW'(w_push) - CW'(w_fetch);
      r_pend    <= w_fetch;
      r_count   <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Output stage: pop shifts slot1 into slot0, then a returning fetch lands
  // in the first free slot (later assignment overrides the shift).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_occ   <= 2'd0;
    end else begin
      if (w_pop) r_slot0 <= r_slot1;
      if (r_pend && (w_occ_mid == 2'd0)) r_slot0 <= w_dout2;
      if (r_pend && (w_occ_mid == 2'd1)) r_slot1 <= w_dout2;
      r_occ <= w_load;
    end
  end

`ifndef SYNTHESIS
  // Occupancy invariants and overflow guard for the output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_count <= CW'(D));
      assert (r_occ <= 2'd2);
      assert (!(r_pend && (w_occ_mid == 2'd2)));
      assert (r_count == r_ram_cnt + CW'(r_pend) + CW'(r_occ));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sr_fwft.sv
// Directed and randomized checks of fifo_sr_fwft at D=8 against a queue model.
module tb_fifo_sr_fwft;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          wr_en   = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_en   = 1'b0;
  logic          full;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic [CW-1:0] count;

  int            n_tests   = 0;
  int            n_fail    = 0;
  logic [W-1:0]  q[$];
  int            model_cnt = 0;
  logic          last_pop  = 1'b0;

  fifo_sr_fwft #(
    .W (W),
    .D (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle of traffic; inputs applied 1ns after the previous edge.
  task automatic cycle(input logic wr, input logic [W-1:0] d, input logic rd);
    logic        push_ok;
    logic        pop_ok;
    logic [31:0] exp_d;
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    check("full", 32'(full), 32'(model_cnt == D));
    push_ok = wr && (model_cnt != D);
    pop_ok  = rd && rd_valid;
    if (pop_ok) begin
      if (q.size() != 0) exp_d = 32'(q.pop_front());
      else               exp_d = 32'hFFFF_FFFF;
      check("pop_data", 32'(rd_data), exp_d);
    end
    if (push_ok) q.push_back(d);
    model_cnt = model_cnt + int'(push_ok) - int'(pop_ok);
    last_pop  = pop_ok;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("count", 32'(count), 32'(model_cnt));
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    model_cnt = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      cycle(1'b0, '0, 1'b1);
      n++;
    end
    check("drain_left", 32'(q.size()), 32'd0);
    check("drain_valid", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int last;
    int npops;
    int maxc;

    // Reset state
    @(posedge clk); #1;
    do_reset();
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data",  32'(rd_data),  32'd0);
    check("rst_full",  32'(full),     32'd0);
    check("rst_count", 32'(count),    32'd0);

    // Single push latency: visible after the second edge following acceptance
    cycle(1'b1, 8'hA5, 1'b0);
    check("lat_e0_valid", 32'(rd_valid), 32'd0);
    check("lat_e0_count", 32'(count), 32'd1);
    cycle(1'b0, '0, 1'b0);
    check("lat_e1_valid", 32'(rd_valid), 32'd0);
    cycle(1'b0, '0, 1'b0);
    check("lat_e2_valid", 32'(rd_valid), 32'd1);
    check("lat_e2_data",  32'(rd_data), 32'hA5);
    cycle(1'b0, '0, 1'b1);
    check("pop1_valid", 32'(rd_valid), 32'd0);
    check("pop1_count", 32'(count), 32'd0);

    // Fill to D, push while full is dropped, drain in order
    for (int i = 0; i < D; i++) cycle(1'b1, W'(i), 1'b0);
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd8);
    cycle(1'b1, 8'hFF, 1'b0);
    check("drop_count", 32'(count), 32'd8);
    drain(40);
    check("drained_count", 32'(count), 32'd0);

    // Streaming 0..99 with rd_en held high
    first = -1; last = -1; npops = 0; maxc = 0;
    for (int i = 0; i < 103; i++) begin
      cycle(i < 100, W'(i), 1'b1);
      if (last_pop) begin
        if (first < 0) first = i;
        last = i;
        npops++;
      end
      if (int'(count) > maxc) maxc = int'(count);
    end
    check("stream_pops",  32'(npops), 32'd100);
    check("stream_first", 32'(first), 32'd3);
    check("stream_last",  32'(last),  32'd102);
    check("stream_maxc",  32'(maxc),  32'd3);
    drain(10);

    // Full with simultaneous push+pop: pop wins, push dropped
    for (int i = 0; i < D; i++) cycle(1'b1, W'(8'h20 + i), 1'b0);
    check("full2", 32'(full), 32'd1);
    cycle(1'b1, 8'h11, 1'b1);
    check("full_pp_count", 32'(count), 32'd7);
    cycle(1'b1, 8'h11, 1'b0);
    check("full_refill_count", 32'(count), 32'd8);
    drain(40);

    // One entry held, simultaneous push+pop
    cycle(1'b1, 8'h55, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("one_valid", 32'(rd_valid), 32'd1);
    cycle(1'b1, 8'h77, 1'b1);
    check("one_pp_count", 32'(count), 32'd1);
    check("one_pp_e0", 32'(rd_valid), 32'd0);
    cycle(1'b0, '0, 1'b0);
    check("one_pp_e1", 32'(rd_valid), 32'd0);
    cycle(1'b0, '0, 1'b0);
    check("one_pp_e2", 32'(rd_valid), 32'd1);
    check("one_pp_data", 32'(rd_data), 32'h77);
    drain(10);

    // Random traffic with back-pressure
    for (int i = 0; i < 10000; i++)
      cycle(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    drain(40);

    // Reset mid-stream with 5 entries and a fetch in flight
    for (int i = 0; i < 6; i++) cycle(1'b1, W'(8'hC0 + i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    check("pre_rst_count", 32'(count), 32'd5);
    do_reset();
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_count", 32'(count),    32'd0);
    check("mid_rst_full",  32'(full),     32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b0);
      check("stale_valid", 32'(rd_valid), 32'd0);
    end
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("post_rst_data", 32'(rd_data), 32'h3C);
    drain(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
